// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder: FSM states, access kinds,
// default widths/latency and the word-offset mask applied to RAM addresses.
package mem_pkg;

  localparam int MEM_ADDR_W  = 32;
  localparam int MEM_DATA_W  = 32;
  localparam int MEM_RAM_LAT = 2;

  // Byte-offset bits cleared to form a word-aligned RAM address.
  localparam logic [1:0] WORD_OFFSET_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    D_ACCESS = 2'd1,
    I_ACCESS = 2'd2,
    DONE     = 2'd3
  } mem_state_e;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } mem_op_e;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with a zero flag; times the RAM access window.
module mem_lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_responder.sv
// Single-port RAM responder serving data and fetch requests one at a time,
// data first, with a fixed access latency and one-cycle ready pulses.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int RAM_LAT = MEM_RAM_LAT
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ren,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ren,
  input  logic              dmem_wen,
  output logic [DATA_W-1:0] instr_out,
  output logic              i_ready,
  output logic [DATA_W-1:0] memload,
  output logic              d_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  output logic              ram_ren,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_load
);

  if ((RAM_LAT < 1) || (RAM_LAT > 15)) begin : g_bad_lat
    $error("mem_responder: RAM_LAT must be within 1..15");
  end

  localparam int              CNT_W    = $clog2(RAM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RAM_LAT - 1);

  mem_state_e        state_q, state_d;
  mem_op_e           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] memload_q, memload_d;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;
  logic              in_access;

  assign in_access = (state_q == D_ACCESS) || (state_q == I_ACCESS);
  assign cnt_dec   = in_access;

  mem_lat_counter #(.W(CNT_W)) u_lat_counter (
    .clk      (clk),
    .rst_n    (nRST),
    .load     (cnt_load),
    .load_val (CNT_INIT),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      op_q      <= OP_FETCH;
      addr_q    <= '0;
      wdata_q   <= '0;
      instr_q   <= '0;
      memload_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      instr_q   <= instr_d;
      memload_q <= memload_d;
    end
  end

  // Request inputs only matter in IDLE; the access runs on the latched copy.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    instr_d   = instr_q;
    memload_d = memload_q;
    cnt_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dmem_wen || dmem_ren) begin
          state_d  = D_ACCESS;
          op_d     = dmem_wen ? OP_STORE : OP_LOAD;
          addr_d   = dmem_addr;
          wdata_d  = dmem_wdata;
          cnt_load = 1'b1;
        end else if (imem_ren) begin
          state_d  = I_ACCESS;
          op_d     = OP_FETCH;
          addr_d   = imem_addr;
          cnt_load = 1'b1;
        end
      end
      D_ACCESS, I_ACCESS: begin
        if (cnt_zero) begin
          state_d = DONE;
          if (op_q == OP_LOAD) memload_d = ram_load;
          if (op_q == OP_FETCH) instr_d = ram_load;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_addr  = '0;
    ram_store = '0;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    if (in_access) begin
      ram_addr  = addr_q & ~ADDR_W'(WORD_OFFSET_MASK);
      ram_store = wdata_q;
      ram_wen   = (op_q == OP_STORE);
      ram_ren   = (op_q != OP_STORE);
    end else if (state_q == DONE) begin
      i_ready = (op_q == OP_FETCH);
      d_ready = (op_q != OP_FETCH);
    end
  end

  assign instr_out = instr_q;
  assign memload   = memload_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder at three latencies (2, 1, 15), checked
// against a transaction-level memory model and expected-value queue.
module tb_mem_responder;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;
  localparam int LAT2 = 15;
  localparam int NDUT = 3;

  logic        clk;
  logic        nrst       [NDUT];
  logic [31:0] imem_addr  [NDUT];
  logic        imem_ren   [NDUT];
  logic [31:0] dmem_addr  [NDUT];
  logic [31:0] dmem_wdata [NDUT];
  logic        dmem_ren   [NDUT];
  logic        dmem_wen   [NDUT];
  logic [31:0] instr_out  [NDUT];
  logic        i_ready    [NDUT];
  logic [31:0] memload    [NDUT];
  logic        d_ready    [NDUT];
  logic [31:0] ram_addr   [NDUT];
  logic [31:0] ram_store  [NDUT];
  logic        ram_ren    [NDUT];
  logic        ram_wen    [NDUT];
  logic [31:0] ram_load   [NDUT];

  logic [31:0] ram_mem    [NDUT][256];
  logic [31:0] model_mem  [NDUT][256];
  logic [31:0] exp_memload[NDUT];
  logic [31:0] exp_instr  [NDUT];
  logic [31:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock / DUTs / RAM ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int L_G = (g == 0) ? LAT0 : ((g == 1) ? LAT1 : LAT2);
    mem_responder #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(L_G)) u_dut (
      .clk        (clk),
      .nRST       (nrst[g]),
      .imem_addr  (imem_addr[g]),
      .imem_ren   (imem_ren[g]),
      .dmem_addr  (dmem_addr[g]),
      .dmem_wdata (dmem_wdata[g]),
      .dmem_ren   (dmem_ren[g]),
      .dmem_wen   (dmem_wen[g]),
      .instr_out  (instr_out[g]),
      .i_ready    (i_ready[g]),
      .memload    (memload[g]),
      .d_ready    (d_ready[g]),
      .ram_addr   (ram_addr[g]),
      .ram_store  (ram_store[g]),
      .ram_ren    (ram_ren[g]),
      .ram_wen    (ram_wen[g]),
      .ram_load   (ram_load[g])
    );
  end

  always @(posedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      if (ram_wen[g]) ram_mem[g][ram_addr[g][9:2]] = ram_store[g];
    end
  end

  always_comb begin
    for (int g = 0; g < NDUT; g++) ram_load[g] = ram_mem[g][ram_addr[g][9:2]];
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic int lat_of(input int g);
    return (g == 0) ? LAT0 : ((g == 1) ? LAT1 : LAT2);
  endfunction

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 32'hBAD0_BAD0;
    return exp_q.pop_front();
  endfunction

  task automatic check_outputs_zero(input int g, input string tag);
    check_val({tag, "_instr"}, instr_out[g], 32'h0);
    check_val({tag, "_memload"}, memload[g], 32'h0);
    check_val({tag, "_ram_addr"}, ram_addr[g], 32'h0);
    check_val({tag, "_ram_store"}, ram_store[g], 32'h0);
    check_val({tag, "_strobes"}, {28'h0, i_ready[g], d_ready[g], ram_ren[g], ram_wen[g]}, 32'h0);
  endtask

  task automatic clear_inputs(input int g);
    imem_addr[g]  = '0;
    imem_ren[g]   = 1'b0;
    dmem_addr[g]  = '0;
    dmem_wdata[g] = '0;
    dmem_ren[g]   = 1'b0;
    dmem_wen[g]   = 1'b0;
  endtask

  // ---------------- driver: one request set, checked end to end ----------------
  task automatic run_req(input int g, input bit do_f, input logic [31:0] fa,
                         input bit d_ren, input bit d_wen,
                         input logic [31:0] da, input logic [31:0] wd);
    int L, lim, d_at, i_at, ren_c, wen_c, bad, ovl;
    bit do_d, is_store, is_load, d_seen;
    logic [31:0] e;
    L = lat_of(g);
    do_d = d_ren | d_wen;
    is_store = d_wen;
    is_load = d_ren && !d_wen;
    d_at = 0; i_at = 0; ren_c = 0; wen_c = 0; bad = 0; ovl = 0; d_seen = 0;
    if (is_load) exp_q.push_back(model_mem[g][da[9:2]]);
    if (is_store) model_mem[g][da[9:2]] = wd;
    if (do_f) exp_q.push_back(model_mem[g][fa[9:2]]);
    imem_addr[g] = fa;  imem_ren[g] = do_f;
    dmem_addr[g] = da;  dmem_wdata[g] = wd;
    dmem_ren[g] = d_ren; dmem_wen[g] = d_wen;
    lim = 2 * L + 8;
    for (int n = 1; n <= lim; n++) begin
      @(posedge clk); #1;
      if (ram_ren[g]) ren_c++;
      if (ram_wen[g]) wen_c++;
      if (ram_ren[g] && ram_wen[g]) ovl++;
      if (i_ready[g] && d_ready[g]) ovl++;
      if (ram_ren[g] || ram_wen[g]) begin
        if (ram_addr[g] !== ((do_d && !d_seen) ? (da & 32'hFFFF_FFFC) : (fa & 32'hFFFF_FFFC))) bad++;
        if (ram_wen[g] && (ram_store[g] !== wd)) bad++;
      end
      if (d_ready[g]) begin
        d_at = n;
        d_seen = 1;
        if (is_load) begin
          e = pop_exp();
          check_val("memload", memload[g], e);
          exp_memload[g] = e;
        end else begin
          check_val("memload_store_hold", memload[g], exp_memload[g]);
        end
        dmem_ren[g] = 1'b0;
        dmem_wen[g] = 1'b0;
      end
      if (i_ready[g]) begin
        i_at = n;
        e = pop_exp();
        check_val("instr_out", instr_out[g], e);
        exp_instr[g] = e;
        imem_ren[g] = 1'b0;
      end
      if ((!do_d || d_at != 0) && (!do_f || i_at != 0)) break;
    end
    if (do_d) check_val("d_ready_cycle", d_at, L + 1);
    if (do_f) check_val("i_ready_cycle", i_at, do_d ? (2 * L + 3) : (L + 1));
    check_val("ren_width", ren_c, (is_load ? L : 0) + (do_f ? L : 0));
    check_val("wen_width", wen_c, is_store ? L : 0);
    check_val("addr_store_bad", bad, 0);
    check_val("overlap", ovl, 0);
    check_val("sb_empty", exp_q.size(), 0);
    exp_q.delete();
    clear_inputs(g);
    @(posedge clk); #1;
    check_val("quiet", {28'h0, i_ready[g], d_ready[g], ram_ren[g], ram_wen[g]}, 32'h0);
    check_val("instr_hold", instr_out[g], exp_instr[g]);
    check_val("memload_hold", memload[g], exp_memload[g]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] wd, da, fa;
    int g, kind;
    for (int i = 0; i < NDUT; i++) begin
      nrst[i] = 1'b1;
      clear_inputs(i);
      exp_memload[i] = '0;
      exp_instr[i] = '0;
      for (int w = 0; w < 256; w++) begin
        wd = $urandom;
        ram_mem[i][w] = wd;
        model_mem[i][w] = wd;
      end
      ram_mem[i][4] = 32'h0000_0013;
      model_mem[i][4] = 32'h0000_0013;
    end
    #3;
    for (int i = 0; i < NDUT; i++) nrst[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) check_outputs_zero(i, "reset");
    for (int i = 0; i < NDUT; i++) nrst[i] = 1'b1;
    @(posedge clk); #1;

    // Directed cases at latency 2
    run_req(0, 1, 32'h0000_0010, 0, 0, 32'h0, 32'h0);
    check_val("fetch_value", exp_instr[0], 32'h0000_0013);
    run_req(0, 0, 32'h0, 0, 1, 32'h0000_0104, 32'hDEAD_BEEF);
    run_req(0, 0, 32'h0, 1, 0, 32'h0000_0104, 32'h0);
    check_val("load_value", exp_memload[0], 32'hDEAD_BEEF);
    run_req(0, 1, 32'h0000_0010, 1, 0, 32'h0000_0104, 32'h0);
    run_req(0, 0, 32'h0, 1, 0, 32'h0000_0107, 32'h0);
    run_req(0, 0, 32'h0, 1, 1, 32'h0000_0108, 32'h1234_5678);
    run_req(0, 0, 32'h0, 1, 0, 32'h0000_0108, 32'h0);
    check_val("dual_op_stored", exp_memload[0], 32'h1234_5678);

    // Reset during the first access cycle of a store
    wd = $urandom;
    imem_ren[0] = 1'b0;
    dmem_addr[0] = 32'h0000_0200; dmem_wdata[0] = wd; dmem_wen[0] = 1'b1;
    @(posedge clk); #1;
    check_val("pre_reset_wen", {31'h0, ram_wen[0]}, 32'h1);
    nrst[0] = 1'b0;
    #1;
    check_outputs_zero(0, "midreset");
    exp_memload[0] = '0;
    exp_instr[0] = '0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      check_val("midreset_no_ready", {31'h0, d_ready[0]}, 32'h0);
    end
    nrst[0] = 1'b1;
    run_req(0, 0, 32'h0, 0, 1, 32'h0000_0200, wd);
    run_req(0, 0, 32'h0, 1, 0, 32'h0000_0200, 32'h0);

    // Latency sweep at 1 and 15
    run_req(1, 1, 32'h0000_0010, 0, 0, 32'h0, 32'h0);
    run_req(1, 0, 32'h0, 0, 1, 32'h0000_0040, $urandom);
    run_req(1, 1, 32'h0000_0040, 1, 0, 32'h0000_0010, 32'h0);
    run_req(2, 1, 32'h0000_0010, 0, 0, 32'h0, 32'h0);
    run_req(2, 0, 32'h0, 0, 1, 32'h0000_0044, $urandom);
    run_req(2, 0, 32'h0, 1, 0, 32'h0000_0044, 32'h0);

    // Random mix across instances
    for (int it = 0; it < 60; it++) begin
      g = $urandom_range(0, NDUT - 1);
      kind = $urandom_range(0, 5);
      da = $urandom;
      fa = ($urandom_range(0, 3) == 0) ? da : $urandom;
      wd = $urandom;
      case (kind)
        0: run_req(g, 1, fa, 0, 0, da, wd);
        1: run_req(g, 0, fa, 1, 0, da, wd);
        2: run_req(g, 0, fa, 0, 1, da, wd);
        3: run_req(g, 0, fa, 1, 1, da, wd);
        4: run_req(g, 1, fa, 1, 0, da, wd);
        default: run_req(g, 1, fa, 0, 1, da, wd);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the core's instruction-fetch and data-access requests. It owns a single shared single-port RAM port and serves one request at a time with a fixed, parameterised access latency. It returns fetched instructions with a one-cycle i_ready pulse and loaded data or store completion with a one-cycle d_ready pulse. Data requests have priority over instruction fetches. The core stalls on ready, so the PC advances only after i_ready.

Parameters:
ADDR_W, 32, address width of core and RAM ports.
DATA_W, 32, data word width.
RAM_LAT, 2, RAM access cycles, legal range 1..15; values outside this range are an elaboration error.

Ports:
clk  in  1  system clock, rising edge.
nRST  in  1  asynchronous active-low reset.
imem_addr  in  ADDR_W  instruction fetch address (PC).
imem_ren  in  1  instruction fetch request, level, held until i_ready.
dmem_addr  in  ADDR_W  data address (ALU result).
dmem_wdata  in  DATA_W  store data.
dmem_ren  in  1  load request, level, held until d_ready.
dmem_wen  in  1  store request, level, held until d_ready.
instr_out  out  DATA_W  last fetched instruction, registered.
i_ready  out  1  one-cycle fetch-complete pulse.
memload  out  DATA_W  last loaded data word, registered.
d_ready  out  1  one-cycle data-complete pulse.
ram_addr  out  ADDR_W  word-aligned RAM address.
ram_store  out  DATA_W  RAM write data.
ram_ren  out  1  RAM read strobe.
ram_wen  out  1  RAM write strobe.
ram_load  in  DATA_W  RAM read data, valid on the last access cycle.

Behaviour:
- Reset (async, nRST=0): state is IDLE. All outputs are 0: instr_out, memload, i_ready, d_ready, ram_* and the latched request registers. Reset in mid-access aborts the access with no ready pulse.
- The FSM has four states: IDLE, D_ACCESS, I_ACCESS, DONE.
- IDLE:
  - If dmem_wen or dmem_ren is high, latch the address, wdata and op, then go to D_ACCESS. The counter loads RAM_LAT-1.
  - Otherwise, if imem_ren is high, latch imem_addr and go to I_ACCESS.
  - Otherwise stay in IDLE.
- Simultaneous requests: the data request is served first. The fetch is served after the data DONE, which makes the core's PC stall.
- dmem_wen and dmem_ren both high: treated as a store. memload is unchanged.
- D_ACCESS / I_ACCESS:
  - Drive ram_addr = {latched_addr[ADDR_W-1:2], 2'b00}, ram_store = latched wdata, and assert ram_wen (store) or ram_ren (load or fetch) for exactly RAM_LAT cycles. The counter decrements each cycle.
  - On the cycle the counter is 0: for a load, sample ram_load into memload; for a fetch, sample it into instr_out. Then go to DONE.
  - Request inputs are ignored while in an ACCESS state; latched values are used.
- DONE:
  - All ram strobes are 0. Pulse d_ready (data op) or i_ready (fetch) high for exactly one cycle, then go to IDLE.
  - The requester updates or drops its request on the clock edge that ends DONE. IDLE samples fresh inputs, so a request is never served twice.
- Latency: request seen in IDLE at cycle t gives ready high in cycle t+RAM_LAT+1. The next request is accepted at t+RAM_LAT+2.
- i_ready and d_ready are never high in the same cycle.
- ram_ren and ram_wen are never high in the same cycle.
- instr_out and memload hold their values between responses.
- Address bits [1:0] are ignored; there are no misalignment faults. Address wrap is native ADDR_W modulo.
- Requests deasserted during an access do not cancel it; the access completes and pulses ready.

Decomposition:
- Package mem_pkg holds:
  - the state enum (IDLE, D_ACCESS, I_ACCESS, DONE);
  - the op enum (OP_FETCH, OP_LOAD, OP_STORE);
  - ADDR_W, DATA_W, RAM_LAT defaults;
  - the word-align mask constant.
- One natural sub-module, mem_lat_counter: a loadable down-counter with a zero flag, width $clog2(RAM_LAT+1).

Test Plan:
- Fetch: RAM_LAT=2, imem_ren=1, imem_addr=0x0000_0010, RAM word 0x0000_0013 -> ram_ren high 2 cycles with ram_addr=0x10. i_ready pulses at t+3 and instr_out=0x0000_0013.
- Load/store: dmem_wen=1, addr=0x0000_0104, wdata=0xDEAD_BEEF -> ram_wen 2 cycles, ram_addr=0x104, d_ready at t+3. Then dmem_ren=1, same addr -> memload=0xDEAD_BEEF, d_ready pulses once.
- Priority: imem_ren=1 and dmem_ren=1 at t -> d_ready at t+3 and i_ready at t+7. The ready pulses never overlap.
- Misaligned and dual-op: dmem_addr=0x0000_0107 gives ram_addr=0x0000_0104. dmem_ren=dmem_wen=1 performs a store, and memload is unchanged.
- Reset mid-access: nRST low during D_ACCESS cycle 1 -> all outputs 0 immediately. No d_ready pulse. After release, a held request restarts from IDLE and completes at its full latency.
- Latency sweep: RAM_LAT=1 and RAM_LAT=15 -> ready at t+2 and t+16 respectively. Strobe width equals RAM_LAT.
